divider_restoring_8bit: RTL and testbench

//   Iterative unsigned divider; subtraction counterpart to the 8-bit ripple adder in the SAP datapath.

---
 rtl/divider_restoring_8bit_pkg.sv | 12 +
 rtl/divider_restoring_8bit_subtractor.sv | 17 +
 rtl/divider_restoring_8bit.sv | 127 ++++++++++++
 tb/tb_divider_restoring_8bit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_restoring_8bit_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and default operand width.
package divider_restoring_8bit_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_restoring_8bit_subtractor.sv
// Trial subtractor for the divider datapath: a - b computed as a + ~b + 1.
// borrow is the inverted carry out, so it is high exactly when b > a.
module subtractor_8bit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic cout;

    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
    assign borrow       = ~cout;

endmodule

// File: rtl/divider_restoring_8bit.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held until the next accepted start.
module divider_restoring_8bit
    import divider_restoring_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Handshake: start is taken on any rising edge where the FSM is in IDLE or DONE;
    // done is a single-cycle pulse and the result ports stay valid until the next accepted start.
    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    logic accept;
    logic accept_zero;
    logic last_step;

    // The remainder stays below the divisor, so a successful trial never sets the top bit.
    logic unused_trial_msb;
    assign unused_trial_msb = trial[WIDTH];

    assign partial = {rem, q[WIDTH-1]};

    subtractor_8bit #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a      (partial),
        .b      ({1'b0, dvsr}),
        .diff   (trial),
        .borrow (borrow)
    );

    assign rem_next = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        last_step   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                state_next = ST_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        accept_zero = 1'b1;
                        state_next  = ST_DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cnt == CW'(1)) begin
                    last_step  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            q           <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvsr        <= divisor;
            q           <= dividend;
            rem         <= '0;
            cnt         <= CW'(WIDTH);
            div_by_zero <= 1'b0;
        end else if (accept_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (state == ST_CALC) begin
            rem <= rem_next;
            q   <= q_next;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                quotient  <= q_next;
                remainder <= rem_next;
            end
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_divider_restoring_8bit.sv
// Self-checking bench for divider_restoring_8bit: directed vectors from the block's test list
// plus randomized divides checked against plain '/' and '%' arithmetic.
module tb_divider_restoring_8bit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int errors;
    int checks;

    divider_restoring_8bit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    // reference model: plain unsigned arithmetic, all-ones quotient on zero divisor
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // driver tasks: all sampling and driving happens 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // returns the cycle index (1 = first cycle after acceptance) at which done is seen, -1 on timeout
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) step();
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/done/dbz=%b required 000", {busy, done, div_by_zero});
        end
        checks++;
        if ({quotient, remainder} !== '0) begin
            errors++;
            $display("FAIL reset_results: q=%h r=%h required 00 00", quotient, remainder);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [W-1:0] va [6] = '{8'hF0, 8'h01, 8'h05, 8'hFF, 8'h00, 8'h80};
        logic [W-1:0] vb [6] = '{8'h0F, 8'h01, 8'h09, 8'h10, 8'h33, 8'h01};
        logic [W-1:0] qa [6] = '{8'h10, 8'h01, 8'h00, 8'h0F, 8'h00, 8'h80};
        logic [W-1:0] ra [6] = '{8'h00, 8'h00, 8'h05, 8'h0F, 8'h00, 8'h00};
        int lat;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i]);
            wait_done(lat, bok);
            checks++;
            if (lat !== 9 || !bok) begin
                errors++;
                $display("FAIL directed_latency[%0d]: done at cycle %0d busy_ok=%0d, required cycle 9 busy_ok=1",
                         i, lat, bok);
            end
            checks++;
            if (quotient !== qa[i] || remainder !== ra[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL directed_result[%0d] %h/%h: q=%h r=%h dbz=%b, required q=%h r=%h dbz=0",
                         i, va[i], vb[i], quotient, remainder, div_by_zero, qa[i], ra[i]);
            end
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL directed_pulse[%0d]: done=%b busy=%b after done cycle, required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        bit bok;
        launch(8'h07, 8'h00);
        wait_done(lat, bok);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: done at cycle %0d, required cycle 1", lat);
        end
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'h07 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%h dbz=%b, required q=ff r=07 dbz=1", quotient, remainder, div_by_zero);
        end
        repeat (3) step();
        checks++;
        if (quotient !== 8'hFF || remainder !== 8'h07 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_hold: q=%h r=%h dbz=%b, required q=ff r=07 dbz=1", quotient, remainder, div_by_zero);
        end
        launch(8'h10, 8'h03);
        checks++;
        if (div_by_zero !== 1'b0 || quotient !== 8'hFF) begin
            errors++;
            $display("FAIL dbz_clear_on_accept: dbz=%b q=%h, required dbz=0 q=ff (held)", div_by_zero, quotient);
        end
        wait_done(lat, bok);
        checks++;
        if (lat !== 9 || quotient !== 8'h05 || remainder !== 8'h01 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL dbz_next_valid: lat=%0d q=%h r=%h dbz=%b, required lat=9 q=05 r=01 dbz=0",
                     lat, quotient, remainder, div_by_zero);
        end
        step();
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er;
        logic ez;
        int lat;
        bit bok;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 4))
                0: b = '0;
                1: b = W'($urandom_range(int'(a) + 1 > 255 ? 255 : int'(a) + 1, 255));
                default: b = W'($urandom);
            endcase
            ref_div(a, b, eq, er, ez);
            launch(a, b);
            wait_done(lat, bok);
            checks++;
            if (lat !== (ez ? 1 : 9) || !bok) begin
                errors++;
                $display("FAIL random_latency[%0d] %h/%h: lat=%0d busy_ok=%0d, required lat=%0d busy_ok=1",
                         i, a, b, lat, bok, ez ? 1 : 9);
            end
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== ez) begin
                errors++;
                $display("FAIL random_result[%0d] %h/%h: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                         i, a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
            repeat ($urandom_range(1, 3)) step();
        end
    endtask

    task automatic test_start_during_calc();
        logic [W-1:0] eq, er;
        logic ez;
        ref_div(8'hC8, 8'h0B, eq, er, ez);
        launch(8'hC8, 8'h0B);
        for (int k = 1; k <= 8; k++) begin
            start    = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            step();
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored_in_calc: done=%b q=%h r=%h dbz=%b, required done=1 q=%h r=%h dbz=0",
                     done, quotient, remainder, div_by_zero, eq, er);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL return_to_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        launch(8'h64, 8'h07);
        wait_done(lat, bok);
        checks++;
        if (lat !== 9 || quotient !== 8'h0E || remainder !== 8'h02) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d q=%h r=%h, required lat=9 q=0e r=02", lat, quotient, remainder);
        end
        launch(8'hFE, 8'h02);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: busy=%b done=%b after start in done cycle, required 1 0", busy, done);
        end
        wait_done(lat, bok);
        checks++;
        if (lat !== 9 || !bok || quotient !== 8'h7F || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d busy_ok=%0d q=%h r=%h dbz=%b, required lat=9 busy_ok=1 q=7f r=00 dbz=0",
                     lat, bok, quotient, remainder, div_by_zero);
        end
        step();
    endtask

    task automatic test_reset_mid_calc();
        int dones;
        launch(8'hAA, 8'h03);
        repeat (3) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_calc_busy: busy=%b before reset, required 1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'h00 || remainder !== 8'h00 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_calc_reset: busy=%b done=%b q=%h r=%h dbz=%b, required 0 0 00 00 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            if (done || busy) dones++;
            step();
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL mid_calc_no_done: %0d cycles with done/busy after abort, required 0", dones);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_div_by_zero();
        test_start_during_calc();
        test_back_to_back();
        test_random();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
